// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes, FSM
// state encoding and the load sign/zero-extension helper.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Shift the addressed lane(s) down to bit 0 and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_BU:   return {24'h0, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_HU:   return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core's memory initiator and the responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] ADDR;
    logic [31:0] DOUT;
    logic        W;
    logic [2:0]  funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] DIN;
    logic        rsp_err;

    modport master (
        output req_valid, ADDR, DOUT, W, funct3, rsp_ready,
        input  req_ready, rsp_valid, DIN, rsp_err
    );

    modport slave (
        input  req_valid, ADDR, DOUT, W, funct3, rsp_ready,
        output req_ready, rsp_valid, DIN, rsp_err
    );
endinterface

// File: rtl/mem_word_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port; contents and read register are intentionally not reset.
module mem_word_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: accepts one RV32 load/store, waits WAIT_STATES cycles,
// performs the RAM access and returns extended load data or an error flag.
module data_mem_responder
    import rv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic        err_q, ld_q;
    logic [1:0]  lane_q;
    logic [2:0]  lf3_q;

    logic        accept, go, bad;
    logic [31:0] a_addr, a_wdata, offset, ram_wdata, ram_rdata;
    logic        a_w;
    logic [2:0]  a_f3;
    logic [3:0]  ram_be;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // With zero wait states the access edge is the accept edge, so the
    // checks and lane logic must look at the live bus instead of the latches.
    assign a_addr  = (state_q == IDLE) ? bus.ADDR   : addr_q;
    assign a_wdata = (state_q == IDLE) ? bus.DOUT   : wdata_q;
    assign a_w     = (state_q == IDLE) ? bus.W      : we_q;
    assign a_f3    = (state_q == IDLE) ? bus.funct3 : f3_q;
    assign offset  = a_addr - BASE_ADDR;

    always_comb begin
        bad = 1'b0;
        if (!(a_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) bad = 1'b1;
        if (a_w && (a_f3 == F3_BU || a_f3 == F3_HU))          bad = 1'b1;
        if ((a_f3 == F3_H || a_f3 == F3_HU) && a_addr[0])    bad = 1'b1;
        if (a_f3 == F3_W && a_addr[1:0] != 2'b00)            bad = 1'b1;
        if ({1'b0, offset} >= SPAN)                          bad = 1'b1;
    end

    always_comb begin
        ram_be    = 4'b1111;
        ram_wdata = a_wdata;
        case (a_f3)
            F3_B: begin
                ram_be    = 4'b0001 << a_addr[1:0];
                ram_wdata = {4{a_wdata[7:0]}};
            end
            F3_H: begin
                ram_be    = 4'b0011 << {a_addr[1], 1'b0};
                ram_wdata = {2{a_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cnt_d = WS;
                    if (WS == 4'd0) begin
                        state_d = RESP;
                        go      = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    go      = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
            lane_q  <= 2'b00;
            lf3_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.ADDR;
                wdata_q <= bus.DOUT;
                we_q    <= bus.W;
                f3_q    <= bus.funct3;
            end
            if (go) begin
                err_q  <= bad;
                ld_q   <= !a_w && !bad;
                lane_q <= a_addr[1:0];
                lf3_q  <= a_f3;
            end
        end
    end

    mem_word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clock   (clock),
        .we_i    (go && a_w && !bad),
        .re_i    (go && !a_w && !bad),
        .addr_i  (offset[AW+1:2]),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // The RAM read register only updates on a good load, so DIN stays put
    // until the next load response; ld_q gates it to zero after stores/errors.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = err_q;
    assign bus.DIN       = ld_q ? load_extend(ram_rdata, lane_q, lf3_q) : 32'h0;

endmodule
